// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Performs a WIDTH-bit add or subtract by time-multiplexing a single 4-bit
// adder slice (fadder_4bit), one nibble per clock, least significant nibble
// first. The carry between nibbles travels only through a register, so the
// requester sees NIBBLES cycles of latency in exchange for a single slice.
//
// Ports (nibble_serial_adder_ctrl):
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset, discards any operation
//   start     in   request, sampled only while idle
//   op_sub    in   0: a+b+cin, 1: a-b (cin ignored)
//   a, b      in   WIDTH-bit operands, sampled with start
//   cin       in   carry-in for add, sampled with start
//   busy      out  high while an operation is in progress
//   done      out  one-cycle pulse when sum/cout/overflow update
//   sum       out  WIDTH-bit result register
//   cout      out  carry out of the MSB nibble (subtract: 1 = no borrow)
//   overflow  out  two's-complement signed overflow
//
// Ports (fadder_4bit): a, b, cin -> sum, carry (purely combinational).
// ---------------------------------------------------------------------------

module fadder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       carry
);
   assign {carry, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
         $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
      end
   endgenerate

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] a_q;      // latched operand A
   logic [WIDTH-1:0] b_q;      // latched effective operand B (b or ~b)
   logic             carry_q;  // carry between nibbles
   logic [WIDTH-1:0] work_q;   // partially assembled result

   logic [3:0]       slice_a;
   logic [3:0]       slice_b;
   logic [3:0]       slice_sum;
   logic             slice_carry;
   logic [WIDTH-1:0] next_work;

   // Select the current nibble of each latched operand and merge the slice
   // result back into the working result at the same position.
   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      slice_a   = a_q[{idx, 2'b00} +: 4];
      slice_b   = b_q[{idx, 2'b00} +: 4];
      next_work = work_q;
      next_work[{idx, 2'b00} +: 4] = slice_sum;
   end

   fadder_4bit u_slice (slice_a, slice_b, carry_q, slice_sum, slice_carry);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         idx      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         work_q   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  // Subtraction is a + ~b + 1: invert b and force carry-in.
                  b_q     <= op_sub ? ~b : b;
                  carry_q <= op_sub ? 1'b1 : cin;
                  idx     <= '0;
                  work_q  <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               work_q  <= next_work;
               carry_q <= slice_carry;
               if (idx == LAST_IDX) begin
                  sum      <= next_work;
                  cout     <= slice_carry;
                  // Same-signed operands producing an opposite-signed result.
                  overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (next_work[WIDTH-1] != a_q[WIDTH-1]);
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  idx      <= '0;
                  state    <= IDLE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
//
// Scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16). Stimulus pushes
// the reference result (computed with plain integer arithmetic) into a queue;
// a monitor pops and compares whenever the DUT pulses done. The stimulus side
// additionally checks busy/done timing and that results hold during RUN.
// ---------------------------------------------------------------------------

module tb_nibble_serial_adder_ctrl;

   localparam int WIDTH   = 16;
   localparam int NIBBLES = WIDTH / 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start;
   logic             op_sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   exp_t sb[$];
   exp_t last_e;
   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;

   nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .op_sub   (op_sub),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: signed/unsigned integer arithmetic on the operands.
   function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                                  input logic tcin, input logic top);
      exp_t e;
      int   ua = int'(ta);
      int   ub = int'(tb_v);
      int   sa = $signed(ta);
      int   sbv = $signed(tb_v);
      int   ru;
      int   rs;
      if (top) begin
         ru     = ua - ub;
         e.cout = (ua >= ub);
         rs     = sa - sbv;
      end else begin
         ru     = ua + ub + int'(tcin);
         e.cout = (ru > 65535);
         rs     = sa + sbv + int'(tcin);
      end
      e.sum = ru[WIDTH-1:0];
      e.ovf = (rs > 32767) || (rs < -32768);
      return e;
   endfunction

   // Monitor: compares every done pulse against the scoreboard head.
   initial begin : monitor
      exp_t e;
      logic prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            if (prev_done) check("done_width", 32'(1), 32'(0));
            if (sb.size() == 0) begin
               check("unexpected_done", 32'(1), 32'(0));
            end else begin
               e = sb.pop_front();
               check("sum", 32'(sum), 32'(e.sum));
               check("cout", 32'(cout), 32'(e.cout));
               check("overflow", 32'(overflow), 32'(e.ovf));
            end
         end
         prev_done = done;
      end
   end

   // Checks that the result registers still show the previous completion.
   task automatic check_hold(input string tag);
      check({tag, "_sum_hold"}, 32'(sum), 32'(last_e.sum));
      check({tag, "_cout_hold"}, 32'(cout), 32'(last_e.cout));
      check({tag, "_ovf_hold"}, 32'(overflow), 32'(last_e.ovf));
   endtask

   // Issue one operation (called near a falling edge) and follow its timing
   // up to the done cycle, where the monitor compares the result.
   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tcin, input logic top);
      exp_t e;
      e = model(ta, tb_v, tcin, top);
      a = ta; b = tb_v; cin = tcin; op_sub = top; start = 1'b1;
      sb.push_back(e);
      for (int i = 0; i < NIBBLES; i++) begin
         @(negedge clk);
         if (i == 0) begin
            start = 1'b0;
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            cin = 1'($urandom); op_sub = 1'($urandom);
         end
         check("busy_run", 32'(busy), 32'(1));
         check("done_run", 32'(done), 32'(0));
         check_hold("run");
      end
      @(negedge clk);
      check("busy_done", 32'(busy), 32'(0));
      check("done_pulse", 32'(done), 32'(1));
      last_e = e;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      exp_t e;
      int   cnt0;
      last_e  = '0;
      reset_n = 1'b0;
      start   = 1'b0;
      op_sub  = 1'b0;
      a = '0; b = '0; cin = 1'b0;

      #3;
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check_hold("rst");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'(0));

      // Directed cases; each is issued in the done cycle of the previous one.
      run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      run_op(16'h00FF, 16'h0000, 1'b1, 1'b0);
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
      run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
      run_op(16'h1234, 16'h1234, 1'b1, 1'b1);   // cin ignored on subtract
      // Back-to-back: accepted in the done cycle, done NIBBLES cycles later.
      run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
      check("b2b_sum", 32'(sum), 32'(16'h1010));

      // Busy protocol: a second start two cycles into RUN is ignored.
      repeat (2) @(negedge clk);
      #1 cnt0 = done_cnt;
      e = model(16'h1111, 16'h1111, 1'b0, 1'b0);
      a = 16'h1111; b = 16'h1111; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'hAAAA; b = 16'h5555; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_ignored", 32'(busy), 32'(1));
      repeat (8) @(negedge clk);
      #1;
      check("busy_one_done", 32'(done_cnt - cnt0), 32'(1));
      check("busy_sum", 32'(sum), 32'(16'h2222));
      check("busy_sb_empty", 32'(sb.size()), 32'(0));
      last_e = e;

      // Reset in the middle of an operation.
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
      sb.push_back(model(16'hFFFF, 16'hFFFF, 1'b0, 1'b0));
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      sb.delete();
      last_e = '0;
      check("mid_rst_busy", 32'(busy), 32'(0));
      check("mid_rst_done", 32'(done), 32'(0));
      check_hold("mid_rst");
      cnt0 = done_cnt;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      check("post_rst_no_done", 32'(done_cnt - cnt0), 32'(0));
      check("post_rst_busy", 32'(busy), 32'(0));
      check_hold("post_rst");

      // Randomized operations.
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
      end

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
